// File: rtl/spi_master_multi_pkg.sv
// Shared types and width helpers for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Edge counter must hold 2*width plus one spare bit.
  function automatic int cnt_w(input int width);
    return $clog2(2 * width) + 1;
  endfunction

  function automatic int sel_w(input int n_ss);
    return (n_ss > 1) ? $clog2(n_ss) : 1;
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// Host-side handshake plus SPI pins of the multi-slave master.
interface spi_master_multi_if #(
  parameter int WIDTH = 8,
  parameter int N_SS  = 4,
  parameter int DIV_W = 8
);
  import spi_pkg::*;

  localparam int SEL_W = sel_w(N_SS);

  logic             start;
  logic             ready;
  logic [WIDTH-1:0] tx_data;
  logic [SEL_W-1:0] ss_sel;
  logic             cpol;
  logic             cpha;
  logic [DIV_W-1:0] clk_div;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             err;
  logic             busy;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [N_SS-1:0]  ss_n;

  modport master (
    input  start, tx_data, ss_sel, cpol, cpha, clk_div, miso,
    output ready, rx_data, rx_valid, err, busy, sclk, mosi, ss_n
  );

  modport slave (
    output start, tx_data, ss_sel, cpol, cpha, clk_div, miso,
    input  ready, rx_data, rx_valid, err, busy, sclk, mosi, ss_n
  );

endinterface

// File: rtl/spi_master_multi_clk_gen.sv
// Half-period divider and SCLK generator; edge strobes mark the posedge at
// which SCLK toggles, so data logic acts on the same edge as the pin.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             edge_en,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  output logic             tick,
  output logic             edge_lead,
  output logic             edge_trail,
  output logic             sclk
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    tick       = en && (cnt_q == clk_div);
    cnt_d      = (!en || tick) ? '0 : cnt_q + 1'b1;
    phase_d    = !edge_en ? 1'b0 : (tick ? ~phase_q : phase_q);
    edge_lead  = edge_en && tick && !phase_q;
    edge_trail = edge_en && tick && phase_q;
    sclk_d     = cpol ^ phase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: runtime CPOL/CPHA and divider, N_SS active-low
// selects, ready/start handshake and one-cycle rx_valid/err strobes.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_SS  = 4,
  parameter int DIV_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_multi_if.master  bus
);

  localparam int SEL_W = sel_w(N_SS);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * WIDTH - 1);

  state_t           state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [N_SS-1:0]  ss_n_q, ss_n_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic             err_q, err_d;

  logic ready_o, busy_o, clk_en, edge_en, cpol_eff;
  logic accept, sel_bad, tick, edge_lead, edge_trail, sample, shift;

  assign accept  = bus.start && (state_q == IDLE);
  assign sel_bad = (int'(bus.ss_sel) >= N_SS);

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst),
    .en         (clk_en),
    .edge_en    (edge_en),
    .clk_div    (div_q),
    .cpol       (cpol_eff),
    .tick       (tick),
    .edge_lead  (edge_lead),
    .edge_trail (edge_trail),
    .sclk       (bus.sclk)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && !sel_bad) state_d = SETUP;
      SETUP:    if (tick) state_d = TRANSFER;
      TRANSFER: if (edge_trail && (edge_cnt_q == LAST_EDGE)) state_d = HOLD;
      HOLD:     if (tick) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // In IDLE the SCLK level follows the live cpol input so the bus is parked
  // at the right polarity before select goes low.
  always_comb begin
    ready_o  = (state_q == IDLE);
    busy_o   = (state_q != IDLE);
    clk_en   = (state_q != IDLE);
    edge_en  = (state_q == TRANSFER);
    cpol_eff = (state_q == IDLE) ? bus.cpol : mode_q.cpol;
  end

  always_comb begin
    mode_d     = mode_q;
    div_d      = div_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    edge_cnt_d = edge_cnt_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;

    sample = mode_q.cpha ? edge_trail : edge_lead;
    shift  = mode_q.cpha ? edge_lead  : edge_trail;

    if (accept) begin
      if (sel_bad) begin
        err_d = 1'b1;
      end else begin
        mode_d     = '{cpol: bus.cpol, cpha: bus.cpha};
        div_d      = bus.clk_div;
        // cpha=0 presents the MSB during SETUP, so the shifter starts one bit on.
        tx_d       = bus.cpha ? bus.tx_data : (bus.tx_data << 1);
        mosi_d     = bus.cpha ? 1'b0 : bus.tx_data[WIDTH-1];
        rx_sh_d    = '0;
        edge_cnt_d = '0;
        for (int i = 0; i < N_SS; i++) begin
          ss_n_d[i] = (SEL_W'(i) != bus.ss_sel);
        end
      end
    end

    if (edge_lead || edge_trail) edge_cnt_d = edge_cnt_q + 1'b1;
    if (sample) rx_sh_d = {rx_sh_q[WIDTH-2:0], bus.miso};
    if (shift) begin
      mosi_d = tx_q[WIDTH-1];
      tx_d   = tx_q << 1;
    end

    if ((state_q == HOLD) && tick) begin
      ss_n_d     = '1;
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      mosi_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= '0;
      div_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      edge_cnt_q <= '0;
      ss_n_q     <= '1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      edge_cnt_q <= edge_cnt_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.ready    = ready_o;
  assign bus.busy     = busy_o;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.err      = err_q;
  assign bus.mosi     = mosi_q;
  assign bus.ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: vector table of full transfers against
// a behavioural SPI slave, plus error, busy-start and mid-transfer reset cases.
module tb_spi_master_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_multi_if #(.WIDTH(8), .N_SS(4), .DIV_W(8)) bif ();
  spi_master_multi_if #(.WIDTH(8), .N_SS(5), .DIV_W(8)) eif ();

  spi_master_multi #(.WIDTH(8), .N_SS(4), .DIV_W(8)) dut (
    .clk (clk), .rst (rst), .bus (bif.master)
  );
  spi_master_multi #(.WIDTH(8), .N_SS(5), .DIV_W(8)) dut_err (
    .clk (clk), .rst (rst), .bus (eif.master)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural slave listening whenever any select is low.
  logic       loop_en = 1'b0;
  logic       slv_cpol = 1'b0, slv_cpha = 1'b0;
  logic [7:0] slv_tx = 8'h00, slv_out = 8'h00, slv_in = 8'h00;
  logic       miso_s = 1'b0;
  logic       slv_sel_n;

  assign slv_sel_n = &bif.ss_n;
  assign bif.miso  = loop_en ? bif.mosi : miso_s;

  always @(negedge slv_sel_n) begin
    slv_out = slv_tx;
    slv_in  = 8'h00;
    if (!slv_cpha) begin
      miso_s  = slv_out[7];
      slv_out = {slv_out[6:0], 1'b0};
    end
  end

  always @(bif.sclk) begin
    if (!slv_sel_n) begin
      if ((bif.sclk != slv_cpol) == !slv_cpha) begin
        slv_in = {slv_in[6:0], bif.mosi};
      end else begin
        miso_s  = slv_out[7];
        slv_out = {slv_out[6:0], 1'b0};
      end
    end
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] slv_tx;
    logic       loop;
    logic [1:0] sel;
    logic [3:0] exp_ss;
    logic [7:0] exp_rx;
    logic [7:0] exp_slv;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  // Runs one transfer; with inject set, a second start carrying 8'hFF is
  // pulsed mid-transfer and must have no effect.
  task automatic run_xfer(input string tag, input vec_t v, input bit inject);
    int  n, toggles, t1, t2;
    bit  got;
    logic prev;
    bif.cpol    = v.cpol;
    bif.cpha    = v.cpha;
    bif.clk_div = v.div;
    bif.tx_data = v.tx;
    bif.ss_sel  = v.sel;
    loop_en     = v.loop;
    slv_tx      = v.slv_tx;
    slv_cpol    = v.cpol;
    slv_cpha    = v.cpha;
    repeat (2) @(negedge clk);
    chk({tag, "_idle_sclk"}, 32'(bif.sclk), 32'(v.cpol));
    chk({tag, "_ready_pre"}, 32'(bif.ready), 32'd1);
    bif.start = 1'b1;
    n = 0; toggles = 0; t1 = 0; t2 = 0; got = 1'b0;
    prev = bif.sclk;
    while (!got && n < 6000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bif.start = 1'b0;
        chk({tag, "_ss_active"}, 32'(bif.ss_n), 32'(v.exp_ss));
        chk({tag, "_busy"}, 32'(bif.busy), 32'd1);
      end
      if (inject && n == 10) begin
        bif.start   = 1'b1;
        bif.tx_data = 8'hFF;
      end
      if (inject && n == 11) begin
        bif.start = 1'b0;
        chk({tag, "_ready_busy"}, 32'(bif.ready), 32'd0);
      end
      if (bif.sclk != prev) begin
        toggles++;
        if (toggles == 1) t1 = n;
        if (toggles == 2) t2 = n;
      end
      prev = bif.sclk;
      if (bif.rx_valid) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no rx_valid within %0d cycles", tag, n);
      return;
    end
    chk({tag, "_latency"}, 32'(n), 32'(v.exp_lat));
    chk({tag, "_rx_data"}, 32'(bif.rx_data), 32'(v.exp_rx));
    chk({tag, "_slave_rx"}, 32'(slv_in), 32'(v.exp_slv));
    chk({tag, "_ss_release"}, 32'(bif.ss_n), 32'hF);
    chk({tag, "_ready_done"}, 32'(bif.ready), 32'd1);
    chk({tag, "_sclk_edges"}, 32'(toggles), 32'd16);
    chk({tag, "_half_period"}, 32'(t2 - t1), 32'(v.div) + 32'd1);
    @(negedge clk);
    chk({tag, "_rx_valid_pulse"}, 32'(bif.rx_valid), 32'd0);
    chk({tag, "_rx_hold"}, 32'(bif.rx_data), 32'(v.exp_rx));
  endtask

  initial begin
    int vcnt;
    //             cpol cpha div    tx     slv_tx loop sel exp_ss    exp_rx exp_slv lat
    vecs[0] = '{1'b0, 1'b0, 8'd0,   8'hA5, 8'h00, 1'b1, 2'd0, 4'b1110, 8'hA5, 8'hA5, 19};
    vecs[1] = '{1'b1, 1'b1, 8'd3,   8'hC3, 8'h3C, 1'b0, 2'd0, 4'b1110, 8'h3C, 8'hC3, 73};
    vecs[2] = '{1'b0, 1'b1, 8'd1,   8'h5A, 8'h96, 1'b0, 2'd1, 4'b1101, 8'h96, 8'h5A, 37};
    vecs[3] = '{1'b1, 1'b0, 8'd2,   8'h0F, 8'hF0, 1'b0, 2'd3, 4'b0111, 8'hF0, 8'h0F, 55};
    vecs[4] = '{1'b0, 1'b0, 8'd0,   8'h81, 8'h7E, 1'b0, 2'd2, 4'b1011, 8'h7E, 8'h81, 19};
    vecs[5] = '{1'b0, 1'b1, 8'd255, 8'h01, 8'h80, 1'b0, 2'd0, 4'b1110, 8'h80, 8'h01, 4609};

    bif.start = 1'b0; bif.tx_data = '0; bif.ss_sel = '0;
    bif.cpol = 1'b0; bif.cpha = 1'b0; bif.clk_div = '0;
    eif.start = 1'b0; eif.tx_data = 8'h55; eif.ss_sel = '0;
    eif.cpol = 1'b0; eif.cpha = 1'b0; eif.clk_div = '0; eif.miso = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bif.ready), 32'd1);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    chk("rst_rx_data", 32'(bif.rx_data), 32'd0);
    chk("rst_sclk", 32'(bif.sclk), 32'd0);
    chk("rst_mosi", 32'(bif.mosi), 32'd0);
    chk("rst_ss_n", 32'(bif.ss_n), 32'hF);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Out-of-range select on the five-slave instance.
    eif.ss_sel = 3'd5;
    eif.start  = 1'b1;
    @(negedge clk);
    eif.start = 1'b0;
    chk("err_pulse", 32'(eif.err), 32'd1);
    chk("err_ss_n", 32'(eif.ss_n), 32'h1F);
    chk("err_ready", 32'(eif.ready), 32'd1);
    chk("err_busy", 32'(eif.busy), 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(eif.err), 32'd0);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (eif.rx_valid || !eif.ready) vcnt++;
    end
    chk("err_no_xfer", 32'(vcnt), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Start while busy is ignored; a fresh start afterwards is honoured.
    run_xfer("busy_start", '{1'b0, 1'b0, 8'd1, 8'h3C, 8'h00, 1'b1, 2'd0, 4'b1110,
                             8'h3C, 8'h3C, 37}, 1'b1);
    run_xfer("after_busy", '{1'b0, 1'b0, 8'd0, 8'h5A, 8'h00, 1'b1, 2'd1, 4'b1101,
                             8'h5A, 8'h5A, 19}, 1'b0);

    // Reset asserted in the middle of a mode-3 transfer.
    bif.cpol = 1'b1; bif.cpha = 1'b1; bif.clk_div = 8'd2;
    bif.tx_data = 8'h99; bif.ss_sel = 2'd0;
    loop_en = 1'b0; slv_cpol = 1'b1; slv_cpha = 1'b1; slv_tx = 8'h11;
    repeat (2) @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy_before", 32'(bif.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(bif.ss_n), 32'hF);
    chk("mid_rst_sclk", 32'(bif.sclk), 32'd0);
    chk("mid_rst_busy", 32'(bif.busy), 32'd0);
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bif.rx_valid) vcnt++;
    end
    rst = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bif.rx_valid) vcnt++;
    end
    chk("mid_rst_no_rx_valid", 32'(vcnt), 32'd0);
    run_xfer("post_rst", vecs[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
